// File: rtl/dma_local_mem_responder.sv
// AVMM responder at the far end of the DMA local-memory read/write interfaces.
// Backs burst reads and writes with an internal byte-enabled buffer.
module dma_local_mem_responder #(
  parameter int DATA_WIDTH       = 512,
  parameter int ADDR_WIDTH       = 33,
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int MEM_DEPTH_LOG2   = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       avs_address,
  input  logic [BURSTCOUNT_WIDTH-1:0] avs_burstcount,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [DATA_WIDTH-1:0]       avs_writedata,
  input  logic [DATA_WIDTH/8-1:0]     avs_byteenable,
  output logic                        avs_waitrequest,
  output logic [DATA_WIDTH-1:0]       avs_readdata,
  output logic                        avs_readdatavalid,
  output logic [31:0]                 rd_burst_count,
  output logic [31:0]                 wr_beat_count,
  output logic                        cmd_error,
  output logic [1:0]                  fsm_state
);

  // Handshake: a command or write beat is taken on any rising edge where it is
  // presented while avs_waitrequest=0; read data is valid only with avs_readdatavalid.

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam logic [MEM_DEPTH_LOG2-1:0]   IDX_ONE = 1;
  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE  = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WR_BURST = 2'd1, RD_BURST = 2'd2} state_t;

  state_t                      state, state_nxt;
  logic [BURSTCOUNT_WIDTH-1:0] remaining, remaining_nxt;
  logic [MEM_DEPTH_LOG2-1:0]   cmd_idx, wr_idx, rd_idx, wr_addr;
  logic                        wr_en, rd_issue, rd_accept, err_set;
  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        rd_valid;
  logic                        addr_unused;

  assign cmd_idx     = avs_address[OFF +: MEM_DEPTH_LOG2];
  assign addr_unused = ^avs_address;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    case (state)
      IDLE: begin
        if (avs_write) begin
          if (avs_burstcount > BC_ONE) begin
            state_nxt     = WR_BURST;
            remaining_nxt = avs_burstcount - BC_ONE;
          end
        end else if (avs_read && avs_burstcount != '0) begin
          state_nxt     = RD_BURST;
          remaining_nxt = avs_burstcount;
        end
      end
      WR_BURST: begin
        if (avs_write) begin
          remaining_nxt = remaining - BC_ONE;
          if (remaining == BC_ONE) state_nxt = IDLE;
        end
      end
      RD_BURST: begin
        remaining_nxt = remaining - BC_ONE;
        if (remaining == BC_ONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = cmd_idx;
    rd_issue  = 1'b0;
    rd_accept = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (avs_write) begin
          if (avs_burstcount != '0) wr_en = 1'b1;
          else                      err_set = 1'b1;
          if (avs_read) err_set = 1'b1;
        end else if (avs_read) begin
          if (avs_burstcount != '0) rd_accept = 1'b1;
          else                      err_set = 1'b1;
        end
      end
      WR_BURST: begin
        wr_addr = wr_idx;
        wr_en   = avs_write;
        err_set = avs_read;
      end
      RD_BURST: rd_issue = 1'b1;
      default: ;
    endcase
  end

  assign avs_waitrequest = reset || (state == RD_BURST);
  assign fsm_state       = state;

  // Buffer is never reset; reads return pre-write data on a same-cycle collision.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_en && avs_byteenable[b]) mem[wr_addr][b*8 +: 8] <= avs_writedata[b*8 +: 8];
    end
    if (rd_issue) rd_data <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx         <= '0;
      rd_idx         <= '0;
      rd_valid       <= 1'b0;
      cmd_error      <= 1'b0;
      rd_burst_count <= '0;
      wr_beat_count  <= '0;
    end else begin
      if (wr_en)     wr_idx <= wr_addr + IDX_ONE;
      if (rd_accept) rd_idx <= cmd_idx;
      else if (rd_issue) rd_idx <= rd_idx + IDX_ONE;
      rd_valid <= rd_issue;
      if (err_set)   cmd_error      <= 1'b1;
      if (rd_accept) rd_burst_count <= rd_burst_count + 32'd1;
      if (wr_en)     wr_beat_count  <= wr_beat_count + 32'd1;
    end
  end

  assign avs_readdatavalid = rd_valid;
  assign avs_readdata      = rd_valid ? rd_data : '0;

endmodule

// File: tb/tb_dma_local_mem_responder.sv
// Directed bench for dma_local_mem_responder: burst write/read, wrap, byteenable,
// back-to-back reads, error flag and mid-burst reset.
module tb_dma_local_mem_responder;

  localparam int DW = 512;
  localparam int AW = 33;
  localparam int BW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] avs_address;
  logic [BW-1:0] avs_burstcount;
  logic          avs_read, avs_write;
  logic [DW-1:0] avs_writedata;
  logic [DW/8-1:0] avs_byteenable;
  logic          avs_waitrequest;
  logic [DW-1:0] avs_readdata;
  logic          avs_readdatavalid;
  logic [31:0]   rd_burst_count, wr_beat_count;
  logic          cmd_error;
  logic [1:0]    fsm_state;

  dma_local_mem_responder dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_burstcount(avs_burstcount),
    .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .rd_burst_count(rd_burst_count), .wr_beat_count(wr_beat_count),
    .cmd_error(cmd_error), .fsm_state(fsm_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  int            beat_cyc_q[$];
  int            n_beats = 0;

  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      beat_cyc_q.push_back(cyc);
      n_beats++;
      if (exp_q.size() == 0) check_eq("unexpected_beat", DW'(avs_readdatavalid), '0);
      else                   check_eq("rd_data", avs_readdata, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int word, input int n, input logic [DW-1:0] base,
                             input logic [DW/8-1:0] be, input logic also_read);
    avs_write      = 1'b1;
    avs_read       = also_read;
    avs_address    = AW'(word * 64);
    avs_burstcount = BW'(n);
    avs_byteenable = be;
    for (int i = 0; i < n; i++) begin
      avs_writedata = base + DW'(i);
      cycle();
      avs_read = 1'b0;
    end
    avs_write = 1'b0;
  endtask

  task automatic read_cmd(input int word, input int n, output int first_beat);
    avs_read       = 1'b1;
    avs_address    = AW'(word * 64);
    avs_burstcount = BW'(n);
    cycle();
    first_beat = cyc + 1;
    avs_read   = 1'b0;
  endtask

  task automatic wait_ready(output int hi);
    hi = 0;
    for (int i = 0; i < 64 && avs_waitrequest; i++) begin
      hi++;
      cycle();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) cycle();
    repeat (3) cycle();
    check_eq("drain_timeout", DW'(exp_q.size()), '0);
  endtask

  localparam logic [DW-1:0] ONES = '1;
  logic [DW-1:0] val_a, val_b;
  int fb1, fb2, hi, beats0;

  initial begin
    val_a = {16{32'hAAAA0001}};
    val_b = val_a + DW'(1);
    reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0;
    avs_address = '0; avs_burstcount = '0; avs_writedata = '0; avs_byteenable = '0;
    repeat (3) cycle();
    check_eq("rst_waitreq", DW'(avs_waitrequest), DW'(1));
    check_eq("rst_rdv", DW'(avs_readdatavalid), '0);
    check_eq("rst_rd_cnt", DW'(rd_burst_count), '0);
    check_eq("rst_wr_cnt", DW'(wr_beat_count), '0);
    check_eq("rst_err", DW'(cmd_error), '0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_waitreq", DW'(avs_waitrequest), '0);

    // Burst write 1..4 then read back
    write_burst(0, 4, DW'(1), ONES[DW/8-1:0], 1'b0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
    beat_cyc_q.delete();
    read_cmd(0, 4, fb1);
    wait_ready(hi);
    check_eq("rd4_waitreq_cycles", DW'(hi), DW'(4));
    drain();
    check_eq("rd4_beats", DW'(beat_cyc_q.size()), DW'(4));
    check_eq("rd4_first_latency", DW'(beat_cyc_q[0]), DW'(fb1));
    check_eq("rd4_last_contig", DW'(beat_cyc_q[3]), DW'(fb1 + 3));
    check_eq("rd_cnt_1", DW'(rd_burst_count), DW'(1));
    check_eq("wr_cnt_4", DW'(wr_beat_count), DW'(4));

    // Wrap from word 1023 to word 0
    write_burst(1023, 2, val_a, ONES[DW/8-1:0], 1'b0);
    exp_q.push_back(val_b);
    read_cmd(0, 1, fb1);
    wait_ready(hi);
    exp_q.push_back(val_a);
    read_cmd(1023, 1, fb1);
    wait_ready(hi);
    drain();

    // Byteenable: only low 4 bytes cleared
    write_burst(5, 1, ONES, ONES[DW/8-1:0], 1'b0);
    write_burst(5, 1, '0, 64'h0F, 1'b0);
    exp_q.push_back({{(DW-32){1'b1}}, 32'h0});
    read_cmd(5, 1, fb1);
    wait_ready(hi);
    drain();
    check_eq("wr_cnt_8", DW'(wr_beat_count), DW'(8));

    // Back-to-back reads of 16 then 1
    write_burst(100, 16, DW'(100), ONES[DW/8-1:0], 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'(100 + i));
    exp_q.push_back(val_a);
    beat_cyc_q.delete();
    beats0 = n_beats;
    read_cmd(100, 16, fb1);
    avs_read = 1'b1; avs_address = AW'(1023 * 64); avs_burstcount = BW'(1);
    wait_ready(hi);
    check_eq("b2b_waitreq_cycles", DW'(hi), DW'(16));
    cycle();
    fb2 = cyc + 1;
    avs_read = 1'b0;
    drain();
    check_eq("b2b_beats", DW'(n_beats - beats0), DW'(17));
    check_eq("b2b_first_latency", DW'(beat_cyc_q[0]), DW'(fb1));
    check_eq("b2b_burst16_contig", DW'(beat_cyc_q[15]), DW'(fb1 + 15));
    check_eq("b2b_second_latency", DW'(beat_cyc_q[16]), DW'(fb2));
    check_eq("rd_cnt_6", DW'(rd_burst_count), DW'(6));
    check_eq("wr_cnt_24", DW'(wr_beat_count), DW'(24));

    // Errors: read+write together, then zero-length read
    check_eq("err_clear", DW'(cmd_error), '0);
    write_burst(200, 1, DW'(32'h55), ONES[DW/8-1:0], 1'b1);
    repeat (3) cycle();
    check_eq("err_rw_set", DW'(cmd_error), DW'(1));
    check_eq("err_rw_wr_cnt", DW'(wr_beat_count), DW'(25));
    check_eq("err_rw_rd_cnt", DW'(rd_burst_count), DW'(6));
    exp_q.push_back(DW'(32'h55));
    read_cmd(200, 1, fb1);
    wait_ready(hi);
    drain();
    beats0 = n_beats;
    read_cmd(200, 0, fb1);
    check_eq("bc0_waitreq", DW'(avs_waitrequest), '0);
    drain();
    check_eq("bc0_no_beats", DW'(n_beats - beats0), '0);
    check_eq("bc0_err_sticky", DW'(cmd_error), DW'(1));
    check_eq("bc0_rd_cnt", DW'(rd_burst_count), DW'(7));

    // Reset during beat 3 of an 8-beat read
    for (int i = 0; i < 8; i++) exp_q.push_back(DW'(100 + i));
    read_cmd(100, 8, fb1);
    repeat (3) cycle();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_waitreq", DW'(avs_waitrequest), DW'(1));
    cycle();
    exp_q.delete();
    beats0 = n_beats;
    check_eq("mid_rst_rdv", DW'(avs_readdatavalid), '0);
    check_eq("mid_rst_rd_cnt", DW'(rd_burst_count), '0);
    check_eq("mid_rst_wr_cnt", DW'(wr_beat_count), '0);
    check_eq("mid_rst_err", DW'(cmd_error), '0);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_release_waitreq", DW'(avs_waitrequest), '0);
    exp_q.push_back(DW'(101));
    beat_cyc_q.delete();
    read_cmd(101, 1, fb1);
    wait_ready(hi);
    drain();
    check_eq("fresh_beats", DW'(n_beats - beats0), DW'(1));
    check_eq("fresh_latency", DW'(beat_cyc_q[0]), DW'(fb1));
    check_eq("fresh_rd_cnt", DW'(rd_burst_count), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
